// File: rtl/arb_pkg.sv
// Shared definitions for the system-memory arbiter: FSM states, owner encoding
// and the read/write direction codes used by the cache controllers.
package arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DONE} arb_state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return (owner == OWNER_D) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sys_bus_arbiter_if.sv
// Bundle of the two cache request channels and the single memory port.
// The arbiter connects through 'master'; caches and memory sit on 'slave'.
interface sys_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              IReq;
  logic              IRW;
  logic [ADDR_W-1:0] IAddr;
  logic [DATA_W-1:0] IWData;
  logic              IReady;
  logic [DATA_W-1:0] IRData;

  logic              DReq;
  logic              DRW;
  logic [ADDR_W-1:0] DAddr;
  logic [DATA_W-1:0] DWData;
  logic              DReady;
  logic [DATA_W-1:0] DRData;

  logic              MemStrobe;
  logic              MemRW;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic [DATA_W-1:0] MemRData;
  logic [1:0]        Grant;

  modport master (
    input  IReq, IRW, IAddr, IWData, DReq, DRW, DAddr, DWData, MemRData,
    output IReady, IRData, DReady, DRData,
    output MemStrobe, MemRW, MemAddr, MemWData, Grant
  );

  modport slave (
    output IReq, IRW, IAddr, IWData, DReq, DRW, DAddr, DWData, MemRData,
    input  IReady, IRData, DReady, DRData,
    input  MemStrobe, MemRW, MemAddr, MemWData, Grant
  );
endinterface

// File: rtl/sys_wait_ctr.sv
// Loadable down-counter that times the memory wait states; stops at zero.
module sys_wait_ctr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_value_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the
// I-cache and D-cache; returns read data with a one-cycle Ready pulse.
module sys_bus_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int WAITSTATE = 2
) (
  input logic               Clk,
  input logic               Reset,
  sys_bus_arbiter_if.master bus
);
  localparam int CNT_W = $clog2(WAITSTATE + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAITSTATE - 1);

  if (WAITSTATE < 1 || WAITSTATE > 15) begin : g_bad_waitstate
    $error("sys_bus_arbiter: WAITSTATE must lie in 1..15");
  end

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              pick;
  logic              ctr_load, ctr_dec, ctr_zero;
  logic [DATA_W-1:0] done_data;

  sys_wait_ctr #(.W(CNT_W)) u_wait_ctr (
    .clk          (Clk),
    .srst         (Reset),
    .load_i       (ctr_load),
    .load_value_i (CNT_LOAD),
    .dec_i        (ctr_dec),
    .zero_o       (ctr_zero)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_I;
      last_q  <= OWNER_I;
      rw_q    <= READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Writes return zero data so a stale read value never leaks to a writer.
  assign done_data = (rw_q == READ) ? rdata_q : '0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    pick     = OWNER_I;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;

    bus.MemStrobe = 1'b0;
    bus.MemRW     = 1'b0;
    bus.MemAddr   = '0;
    bus.MemWData  = '0;
    bus.Grant     = 2'b00;
    bus.IReady    = 1'b0;
    bus.IRData    = '0;
    bus.DReady    = 1'b0;
    bus.DRData    = '0;

    case (state_q)
      ARB_IDLE: begin
        if (bus.IReq || bus.DReq) begin
          if (bus.IReq && bus.DReq) begin
            pick = ~last_q;
          end else begin
            pick = bus.DReq ? OWNER_D : OWNER_I;
          end
          owner_d  = pick;
          rw_d     = (pick == OWNER_D) ? bus.DRW    : bus.IRW;
          addr_d   = (pick == OWNER_D) ? bus.DAddr  : bus.IAddr;
          wdata_d  = (pick == OWNER_D) ? bus.DWData : bus.IWData;
          ctr_load = 1'b1;
          state_d  = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        bus.MemStrobe = 1'b1;
        bus.MemRW     = rw_q;
        bus.MemAddr   = addr_q;
        bus.MemWData  = (rw_q == WRITE) ? wdata_q : '0;
        bus.Grant     = owner_onehot(owner_q);
        ctr_dec       = 1'b1;
        if (ctr_zero) begin
          if (rw_q == READ) begin
            rdata_d = bus.MemRData;
          end
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        if (owner_q == OWNER_D) begin
          bus.DReady = 1'b1;
          bus.DRData = done_data;
        end else begin
          bus.IReady = 1'b1;
          bus.IRData = done_data;
        end
        last_d  = owner_q;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end
endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Bench for sys_bus_arbiter: scoreboarded transactions from two requester
// models, a vector table of request mixes, and hand sequences for corner cases.
`timescale 1ns/1ps
module tb_sys_bus_arbiter;
  import arb_pkg::*;

  localparam int WS0 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sys_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();
  sys_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  sys_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAITSTATE(WS0)) u_dut (
    .Clk(clk), .Reset(rst), .bus(b.master));
  sys_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAITSTATE(1)) u_dut1 (
    .Clk(clk), .Reset(rst), .bus(b1.master));

  typedef struct { bit d; bit rw; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { bit d; bit rw; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; } exp_t;
  typedef struct {
    bit i_en; bit i_rw; logic [31:0] i_addr; logic [31:0] i_wdata;
    bit d_en; bit d_rw; logic [31:0] d_addr; logic [31:0] d_wdata;
    bit d_first;
  } vec_t;

  int checks = 0;
  int errors = 0;
  req_t iq[$];
  req_t dq[$];
  exp_t sb[$];
  bit mon_en = 1'b0;
  int bidx = 0;
  logic [15:0] order_log = '0;

  logic [133:0] b_outs;
  assign b_outs = {b.MemStrobe, b.MemRW, b.MemAddr, b.MemWData, b.Grant,
                   b.IReady, b.DReady, b.IRData, b.DRData};

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hCAFE0000 ^ (a >> 8);
  endfunction

  assign b1.MemRData = b1.MemStrobe ? memf(b1.MemAddr) : 32'hDEADBEEF;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic unexpected(input string name, input int qsize);
    checks++;
    errors++;
    $display("FAIL %s: event with scoreboard size %0d, expected none", name, qsize);
  endtask

  function automatic void issue(input bit d, input bit rw, input logic [31:0] addr,
                                input logic [31:0] wdata);
    req_t r;
    exp_t e;
    r = '{d, rw, addr, wdata};
    e = '{d, rw, addr, wdata, (rw ? 32'h0 : memf(addr))};
    if (d) dq.push_back(r);
    else   iq.push_back(r);
    sb.push_back(e);
  endfunction

  // Monitor, memory model and the two requester models share one process.
  always @(negedge clk) begin
    exp_t e;
    req_t r;
    if (mon_en) begin
      if (b.MemStrobe) begin
        if (sb.size() == 0) unexpected("strobe_unexpected", 0);
        else begin
          e = sb[0];
          chk("busy_grant", {158'd0, b.Grant}, e.d ? 160'd2 : 160'd1);
          chk("busy_mem_addr", {128'd0, b.MemAddr}, {128'd0, e.addr});
          chk("busy_mem_rw", {159'd0, b.MemRW}, {159'd0, e.rw});
          if (e.rw) chk("busy_mem_wdata", {128'd0, b.MemWData}, {128'd0, e.wdata});
        end
      end
      if (b.IReady || b.DReady) begin
        if (sb.size() == 0) unexpected("ready_unexpected", 0);
        else begin
          e = sb.pop_front();
          chk("ready_owner", {158'd0, b.DReady, b.IReady}, e.d ? 160'd2 : 160'd1);
          chk("ready_rdata", {128'd0, (e.d ? b.DRData : b.IRData)}, {128'd0, e.rdata});
          order_log = {order_log[14:0], b.DReady};
        end
      end
    end
    if (b.MemStrobe) begin
      b.MemRData = (bidx == WS0 - 1) ? memf(b.MemAddr) : 32'hDEADBEEF;
      bidx++;
    end else begin
      bidx = 0;
      b.MemRData = 32'hDEADBEEF;
    end
    if (b.IReady) b.IReq = 1'b0;
    if (b.DReady) b.DReq = 1'b0;
    if (!b.IReq && iq.size() > 0) begin
      r = iq.pop_front();
      b.IReq = 1'b1; b.IRW = r.rw; b.IAddr = r.addr; b.IWData = r.wdata;
    end
    if (!b.DReq && dq.size() > 0) begin
      r = dq.pop_front();
      b.DReq = 1'b1; b.DRW = r.rw; b.DAddr = r.addr; b.DWData = r.wdata;
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    b.IReq = 1'b0;
    b.DReq = 1'b0;
    iq.delete();
    dq.delete();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 160'(sb.size()), 160'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    logic [15:0] gseq;
    logic [7:0]  rseq;
    logic [7:0]  sseq;
    logic [31:0] data_seen;
    int rdy_seen;
    int gnt_seen;

    vecs[0] = '{1'b0, READ, 32'h0, 32'h0,   1'b1, READ,  32'h200, 32'h0,    1'b1};
    vecs[1] = '{1'b1, READ, 32'h300, 32'h0, 1'b1, WRITE, 32'h204, 32'h1234, 1'b0};
    vecs[2] = '{1'b1, WRITE, 32'h48, 32'h77, 1'b1, READ, 32'h400, 32'h0,    1'b0};
    vecs[3] = '{1'b1, READ, 32'h500, 32'h0, 1'b0, READ,  32'h0,   32'h0,    1'b0};
    vecs[4] = '{1'b1, READ, 32'h600, 32'h0, 1'b1, READ,  32'h700, 32'h0,    1'b1};

    b.IReq = 1'b0; b.IRW = 1'b0; b.IAddr = '0; b.IWData = '0;
    b.DReq = 1'b0; b.DRW = 1'b0; b.DAddr = '0; b.DWData = '0;
    b1.IReq = 1'b0; b1.IRW = 1'b0; b1.IAddr = '0; b1.IWData = '0;
    b1.DReq = 1'b0; b1.DRW = 1'b0; b1.DAddr = '0; b1.DWData = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {26'd0, b_outs}, 160'd0);

    // 1: lone D read, latency and captured data
    do_reset();
    issue(1'b1, READ, 32'h100, 32'h0);
    gseq = '0; rseq = '0; data_seen = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      gseq = {gseq[13:0], b.Grant};
      rseq = {rseq[6:0], b.DReady};
      if (b.DReady) data_seen = b.DRData;
    end
    chk("t1_grant_seq", {148'd0, gseq[11:0]}, {148'd0, 12'b00_10_10_00_00_00});
    chk("t1_dready_seq", {154'd0, rseq[5:0]}, {154'd0, 6'b000100});
    chk("t1_drdata", {128'd0, data_seen}, {128'd0, 32'hCAFE0001});
    drain("t1_drain", 20);

    // 2: simultaneous requests after reset, D first then I after one idle cycle
    do_reset();
    issue(1'b1, READ, 32'h180, 32'h0);
    issue(1'b0, READ, 32'h240, 32'h0);
    gseq = '0; rseq = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      gseq = {gseq[13:0], b.Grant};
      rseq = {rseq[6:0], b.IReady};
    end
    chk("t2_grant_seq", {144'd0, gseq}, {144'd0, 16'b00_10_10_00_00_01_01_00});
    chk("t2_iready_seq", {152'd0, rseq}, {152'd0, 8'b00000001});
    drain("t2_drain", 20);

    // 3: both requesters continuously busy for six transactions
    do_reset();
    order_log = '0;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, (i == 1) ? WRITE : READ, 32'h1000 + 32'(i) * 32'h100, 32'hD000 + 32'(i));
      issue(1'b0, READ, 32'h2000 + 32'(i) * 32'h100, 32'h0);
    end
    drain("t3_drain", 60);
    chk("t3_order", {154'd0, order_log[5:0]}, {154'd0, 6'b101010});

    // Vector table: mixes of single and contending requests
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].d_first) begin
        if (vecs[v].d_en) issue(1'b1, vecs[v].d_rw, vecs[v].d_addr, vecs[v].d_wdata);
        if (vecs[v].i_en) issue(1'b0, vecs[v].i_rw, vecs[v].i_addr, vecs[v].i_wdata);
      end else begin
        if (vecs[v].i_en) issue(1'b0, vecs[v].i_rw, vecs[v].i_addr, vecs[v].i_wdata);
        if (vecs[v].d_en) issue(1'b1, vecs[v].d_rw, vecs[v].d_addr, vecs[v].d_wdata);
      end
      drain($sformatf("vec%0d_drain", v), 40);
    end

    // 4: I write whose inputs change while BUSY
    issue(1'b0, WRITE, 32'h40, 32'h55);
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
    b.IWData = 32'hAA;
    b.IAddr  = 32'h44;
    @(posedge clk);
    #1;
    chk("t4_mem_wdata", {128'd0, b.MemWData}, {128'd0, 32'h55});
    chk("t4_mem_rw", {159'd0, b.MemRW}, {159'd0, WRITE});
    drain("t4_drain", 20);

    // 5: reset during the first BUSY cycle of a D read
    issue(1'b1, READ, 32'h800, 32'h0);
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t5_in_busy", {159'd0, b.MemStrobe}, 160'd1);
    mon_en = 1'b0;
    rst = 1'b1;
    b.DReq = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_outputs_zero", {26'd0, b_outs}, 160'd0);
    rst = 1'b0;
    sb.delete();
    rdy_seen = 0;
    gnt_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (b.DReady || b.IReady) rdy_seen++;
      if (b.Grant != 2'b00) gnt_seen++;
    end
    chk("t5_no_ready", 160'(rdy_seen), 160'd0);
    chk("t5_no_grant", 160'(gnt_seen), 160'd0);
    mon_en = 1'b1;

    // 6: WAITSTATE=1 build, single I read
    @(posedge clk);
    #1;
    b1.IReq = 1'b1; b1.IRW = READ; b1.IAddr = 32'h900; b1.IWData = '0;
    gseq = '0; rseq = '0; sseq = '0; data_seen = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      gseq = {gseq[13:0], b1.Grant};
      sseq = {sseq[6:0], b1.MemStrobe};
      rseq = {rseq[6:0], b1.IReady};
      if (b1.IReady) begin
        data_seen = b1.IRData;
        b1.IReq = 1'b0;
      end
    end
    chk("t6_strobe_seq", {156'd0, sseq[3:0]}, {156'd0, 4'b0100});
    chk("t6_iready_seq", {156'd0, rseq[3:0]}, {156'd0, 4'b0010});
    chk("t6_grant_seq", {152'd0, gseq[7:0]}, {152'd0, 8'b00_01_00_00});
    chk("t6_irdata", {128'd0, data_seen}, {128'd0, 32'hCAFE0009});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
